// File: rtl/line_steer_ctrl.sv
// rtl/line_steer_ctrl.sv - line-following steering controller with PWM motor drive; STEER_DEADBAND_EN enables the error deadband
module line_steer_ctrl #(
  parameter int IMG_W       = 640,
  parameter int PWM_PERIOD  = 1000,
  parameter int BASE_DUTY   = 600,
  parameter int KP_NUM      = 3,
  parameter int KP_SHIFT    = 2,
  parameter int HOLD_CYCLES = 50000,
  parameter int SEARCH_DUTY = 300,
  parameter int DEADBAND    = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [10:0]        centroid_x,
  input  logic               line_valid,
  input  logic               line_lost,
  output logic               pwm_left,
  output logic               pwm_right,
  output logic [9:0]         duty_left,
  output logic [9:0]         duty_right,
  output logic [1:0]         state,
  output logic signed [11:0] steer_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TRACK  = 2'd1,
    HOLD   = 2'd2,
    SEARCH = 2'd3
  } state_t;

  localparam int                HOLD_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [9:0]        CNT_LAST  = 10'(PWM_PERIOD - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic signed [16:0] BASE_S   = 17'(BASE_DUTY);
  localparam logic signed [16:0] PERIOD_S = 17'(PWM_PERIOD);
  localparam logic [9:0]        SEARCH_D  = 10'(SEARCH_DUTY);
  localparam logic [9:0]        PERIOD_D  = 10'(PWM_PERIOD);

  state_t                   state_q;
  state_t                   state_d;
  logic [9:0]               cnt;
  logic                     cnt_wrap;
  logic [HOLD_W-1:0]        hold_cnt;
  logic                     sample_ok;
  logic signed [11:0]       err_raw;
  logic signed [11:0]       err_eff;
  logic signed [16:0]       prod;
  logic signed [16:0]       corr_shift;
  logic signed [16:0]       corr_sat;
  logic signed [16:0]       left_s;
  logic signed [16:0]       right_s;
  logic [9:0]               track_left;
  logic [9:0]               track_right;
  logic [9:0]               shadow_left;
  logic [9:0]               shadow_right;
  logic [9:0]               shadow_left_d;
  logic [9:0]               shadow_right_d;

  // A lost indication overrides a simultaneous valid strobe
  assign sample_ok = line_valid & ~line_lost;
  assign err_raw   = $signed({1'b0, centroid_x} - 12'(IMG_W / 2));
  assign cnt_wrap  = (cnt == CNT_LAST);
  assign state     = state_q;

`ifdef STEER_DEADBAND_EN
  localparam logic signed [11:0] DB_LIM = 12'(DEADBAND);
  logic signed [11:0] err_mag;
  // Small errors steer straight; steer_err itself keeps the raw value
  assign err_mag = steer_err[11] ? -steer_err : steer_err;
  assign err_eff = (err_mag <= DB_LIM) ? 12'sd0 : steer_err;
`else
  assign err_eff = steer_err;
`endif

  // Proportional correction, saturated to the base duty, then clamped into the PWM range
  assign prod        = 17'(err_eff) * 17'(KP_NUM);
  assign corr_shift  = prod >>> KP_SHIFT;
  assign corr_sat    = (corr_shift > BASE_S)  ? BASE_S  :
                       (corr_shift < -BASE_S) ? -BASE_S : corr_shift;
  assign left_s      = BASE_S + corr_sat;
  assign right_s     = BASE_S - corr_sat;
  assign track_left  = (left_s < 17'sd0)   ? 10'd0 :
                       (left_s > PERIOD_S)  ? PERIOD_D : left_s[9:0];
  assign track_right = (right_s < 17'sd0)  ? 10'd0 :
                       (right_s > PERIOD_S) ? PERIOD_D : right_s[9:0];

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state: disable always returns to IDLE, a valid sample always resumes tracking
  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (sample_ok) state_d = TRACK;
        TRACK:   if (line_lost) state_d = HOLD;
        HOLD: begin
          if (sample_ok)                    state_d = TRACK;
          else if (hold_cnt == HOLD_LAST)   state_d = SEARCH;
        end
        SEARCH:  if (sample_ok) state_d = TRACK;
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM outputs: per-state choice of the next shadow duties
  always_comb begin
    shadow_left_d  = shadow_left;
    shadow_right_d = shadow_right;
    if (!enable) begin
      shadow_left_d  = 10'd0;
      shadow_right_d = 10'd0;
    end else begin
      case (state_q)
        IDLE: begin
          shadow_left_d  = 10'd0;
          shadow_right_d = 10'd0;
        end
        TRACK: begin
          shadow_left_d  = track_left;
          shadow_right_d = track_right;
        end
        HOLD: begin
          shadow_left_d  = shadow_left;
          shadow_right_d = shadow_right;
        end
        SEARCH: begin
          shadow_left_d  = steer_err[11] ? 10'd0 : SEARCH_D;
          shadow_right_d = steer_err[11] ? SEARCH_D : 10'd0;
        end
        default: begin
          shadow_left_d  = 10'd0;
          shadow_right_d = 10'd0;
        end
      endcase
    end
  end

  // Error capture and shadow duty registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      steer_err    <= 12'sd0;
      shadow_left  <= 10'd0;
      shadow_right <= 10'd0;
    end else begin
      if (enable && sample_ok) steer_err <= err_raw;
      shadow_left  <= shadow_left_d;
      shadow_right <= shadow_right_d;
    end
  end

  // Free-running PWM period counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        cnt <= 10'd0;
    else if (cnt_wrap) cnt <= 10'd0;
    else               cnt <= cnt + 10'd1;
  end

  // Active duties change only at the period boundary, except disable which zeroes them at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_left  <= 10'd0;
      duty_right <= 10'd0;
    end else if (!enable) begin
      duty_left  <= 10'd0;
      duty_right <= 10'd0;
    end else if (cnt_wrap) begin
      duty_left  <= shadow_left;
      duty_right <= shadow_right;
    end
  end

  // Hold timer restarts from zero whenever HOLD is not the current state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     hold_cnt <= '0;
    else if (state_q != HOLD)       hold_cnt <= '0;
    else if (hold_cnt != HOLD_LAST) hold_cnt <= hold_cnt + 1'b1;
  end

  // Registered PWM compare
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_left  <= 1'b0;
      pwm_right <= 1'b0;
    end else begin
      pwm_left  <= (cnt < duty_left);
      pwm_right <= (cnt < duty_right);
    end
  end

endmodule
